shared_data_ram: RTL

SHARED_DATA_RAM -- requirements
Module: shared_data_ram

---
 rtl/shared_ram_pkg.sv | 17 +
 rtl/shared_ram_arbiter.sv | 40 ++++
 rtl/shared_data_ram.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/shared_ram_pkg.sv
// shared_ram_pkg
//   Shared definitions for the multi-port shared data RAM:
//   - default configuration constants (ports, data width, address width, depth)
//   - FSM state enumeration used by the top level (INIT sweep, RUN service)
package shared_ram_pkg;

  localparam int DEF_NPORTS = 2;
  localparam int DEF_DW     = 16;
  localparam int DEF_AW     = 9;
  localparam int DEF_DEPTH  = 32;

  typedef enum logic {
    INIT = 1'b0,   // clearing memory one word per cycle, requests ignored
    RUN  = 1'b1    // normal service
  } ram_state_e;

endpackage

// File: rtl/shared_ram_arbiter.sv
// shared_ram_arbiter
//   Combinational same-address write resolver. Among all ports requesting a
//   write this cycle, the lowest-indexed port targeting a given address
//   commits; every higher-indexed port aiming at the same address is flagged
//   as colliding and must not touch memory.
// Ports:
//   wr_req   in   NPORTS        qualified write request (in range, RUN only)
//   wr_addr  in   NPORTS x AW   per-port address
//   commit   out  NPORTS        write may be performed
//   collide  out  NPORTS        write dropped in favour of a lower port
module shared_ram_arbiter
  import shared_ram_pkg::*;
#(
  parameter int NPORTS = DEF_NPORTS,
  parameter int AW     = DEF_AW
) (
  input  logic [NPORTS-1:0]         wr_req,
  input  logic [NPORTS-1:0][AW-1:0] wr_addr,
  output logic [NPORTS-1:0]         commit,
  output logic [NPORTS-1:0]         collide
);

  always_comb begin
    commit  = '0;
    collide = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (wr_req[i]) begin
        commit[i] = 1'b1;
        // any lower-indexed writer to the same word takes precedence
        for (int j = 0; j < i; j++) begin
          if (wr_req[j] && (wr_addr[j] == wr_addr[i])) begin
            commit[i]  = 1'b0;
            collide[i] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/shared_data_ram.sv
// shared_data_ram
//   NPORTS-port shared data RAM with independent read/write on every port,
//   registered read data (latency 1), same-address write arbitration and
//   out-of-range detection. After reset the array is cleared by a sweep of
//   DEPTH cycles (state INIT); requests are served only in RUN (ready = 1).
//
//   Optional feature macro: SHARED_RAM_WRITE_FIRST_EN
//     defined   : a read of a word written in the same cycle returns the
//                 winning writer's wdata (write-first forwarding)
//     undefined : such a read returns the old contents (read-first)
//
// Ports:
//   clk        in   1            clock, all state on rising edge
//   rst        in   1            synchronous active-high reset
//   req        in   NPORTS       per-port access request
//   we         in   NPORTS       per-port write enable (qualified by req)
//   addr       in   NPORTS*AW    packed addresses, port 0 in LSBs
//   wdata      in   NPORTS*DW    packed write data
//   rdata      out  NPORTS*DW    packed registered read data (held)
//   rvalid     out  NPORTS       pulse: rdata updated for that port
//   collision  out  NPORTS       pulse: that port's write was dropped
//   oor_err    out  NPORTS       pulse: that port's address was >= DEPTH
//   ready      out  1            initialisation done, requests accepted
module shared_data_ram
  import shared_ram_pkg::*;
#(
  parameter int NPORTS = DEF_NPORTS,
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS-1:0]    we,
  input  logic [NPORTS*AW-1:0] addr,
  input  logic [NPORTS*DW-1:0] wdata,
  output logic [NPORTS*DW-1:0] rdata,
  output logic [NPORTS-1:0]    rvalid,
  output logic [NPORTS-1:0]    collision,
  output logic [NPORTS-1:0]    oor_err,
  output logic                 ready
);

  // index width into the implemented words
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  ram_state_e                   state;
  logic [IW-1:0]                sweep;
  logic [DW-1:0]                mem [DEPTH];

  logic [NPORTS-1:0][AW-1:0]    a;
  logic [NPORTS-1:0][DW-1:0]    wd;
  logic [NPORTS-1:0][DW-1:0]    rd_q;
  logic [NPORTS-1:0][DW-1:0]    rd_word;

  logic                         run;
  logic [NPORTS-1:0]            in_rng;
  logic [NPORTS-1:0]            wr_req;
  logic [NPORTS-1:0]            rd_req;
  logic [NPORTS-1:0]            oor;
  logic [NPORTS-1:0]            commit;
  logic [NPORTS-1:0]            collide;

  assign a     = addr;
  assign wd    = wdata;
  assign rdata = rd_q;

  // a request presented together with rst is discarded
  assign run = (state == RUN) && !rst;

  always_comb begin
    for (int p = 0; p < NPORTS; p++)
      in_rng[p] = ({1'b0, a[p]} < (AW+1)'(DEPTH));
  end

  // out-of-range writers are removed before arbitration so they never
  // block or get blocked by an in-range writer
  assign wr_req = run ? (req &  we & in_rng) : '0;
  assign rd_req = run ? (req & ~we)          : '0;
  assign oor    = run ? (req & ~in_rng)      : '0;

  shared_ram_arbiter #(
    .NPORTS (NPORTS),
    .AW     (AW)
  ) u_arb (
    .wr_req  (wr_req),
    .wr_addr (a),
    .commit  (commit),
    .collide (collide)
  );

  // read word selection; committed writers target distinct words so at most
  // one forwarding source can match
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      rd_word[p] = mem[a[p][IW-1:0]];
`ifdef SHARED_RAM_WRITE_FIRST_EN
      for (int j = 0; j < NPORTS; j++) begin
        if (commit[j] && (a[j] == a[p]))
          rd_word[p] = wd[j];
      end
`endif
    end
  end

  // storage: init sweep and committed writes never coincide (INIT vs RUN)
  always_ff @(posedge clk) begin
    if (!rst && (state == INIT))
      mem[sweep] <= '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (commit[p])
        mem[a[p][IW-1:0]] <= wd[p];
    end
  end

  // control FSM and registered responses
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      sweep     <= '0;
      ready     <= 1'b0;
      rd_q      <= '0;
      rvalid    <= '0;
      collision <= '0;
      oor_err   <= '0;
    end else begin
      rvalid    <= rd_req;
      collision <= collide;
      oor_err   <= oor;
      for (int p = 0; p < NPORTS; p++) begin
        if (rd_req[p])
          rd_q[p] <= in_rng[p] ? rd_word[p] : '0;
      end
      case (state)
        INIT: begin
          sweep <= sweep + IW'(1);
          if (sweep == IW'(DEPTH - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= RUN;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
